demux_stream: RTL

//  1->4 registered stream demultiplexer; the write-side counterpart of Mux.

---
 rtl/demux_stream.sv | 98 +++++++++
 1 files changed

// File: rtl/demux_stream.sv
// ============================================================================
//  Module   : demux_stream
//  Purpose  : 1->4 registered stream demultiplexer with per-channel holding
//             registers. Optional saturating drop counter: DEMUX_DROP_COUNT_EN.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module demux_stream #(
  parameter int DataWidth  = 8,
  parameter int SelectSize = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [SelectSize-1:0] Select,
  input  logic [DataWidth-1:0]  DIn,
  input  logic                  DInValid,
  output logic                  DInReady,
  output logic [DataWidth-1:0]  DOut0,
  output logic [DataWidth-1:0]  DOut1,
  output logic [DataWidth-1:0]  DOut2,
  output logic [DataWidth-1:0]  DOut3,
  output logic [3:0]            DOutValid,
  input  logic [3:0]            DOutReady,
  output logic                  Drop,
  output logic [15:0]           DropCount
);

  logic [31:0]          w_sel_ext;
  logic                 w_in_range;
  logic [1:0]           w_idx;
  logic                 w_accept;
  logic [3:0]           w_wr;
  logic [DataWidth-1:0] r_data [4];
  logic [3:0]           r_valid;
  logic                 r_drop;

  assign w_sel_ext  = 32'(Select);
  assign w_in_range = (w_sel_ext < 32'd4);
  assign w_idx      = Select[1:0];

  // Out-of-range words are always sunk, so they never stall the producer.
  assign DInReady = w_in_range ? (!r_valid[w_idx] || DOutReady[w_idx]) : 1'b1;
  assign w_accept = DInValid && DInReady;

  always_comb begin
    w_wr = 4'b0000;
    if (w_accept && w_in_range) begin
      w_wr[w_idx] = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int n = 0; n < 4; n++) begin
        r_data[n] <= '0;
      end
      r_valid <= 4'b0000;
      r_drop  <= 1'b0;
    end else begin
      for (int n = 0; n < 4; n++) begin
        if (w_wr[n]) begin
          r_data[n]  <= DIn;
          r_valid[n] <= 1'b1;
        end else if (DOutReady[n]) begin
          r_valid[n] <= 1'b0;
        end
      end
      r_drop <= w_accept && !w_in_range;
    end
  end

`ifdef DEMUX_DROP_COUNT_EN
  logic [15:0] r_drop_count;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_drop_count <= 16'h0000;
    end else if (w_accept && !w_in_range && (r_drop_count != 16'hFFFF)) begin
      r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign DropCount = r_drop_count;
`else
  assign DropCount = 16'h0000;
`endif

  assign DOut0     = r_data[0];
  assign DOut1     = r_data[1];
  assign DOut2     = r_data[2];
  assign DOut3     = r_data[3];
  assign DOutValid = r_valid;
  assign Drop      = r_drop;

endmodule

`default_nettype wire
